// File: rtl/fpow_int.sv
// fpow_int: iterative float32 x^n by square-and-multiply over one shared fmul.
// Optional macro FPOW_EARLY_EXIT_EN: trivial bases (+-1.0, +-0) finish in IDLE without multiplying.

module fmul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p,
    output logic        ovf,
    output logic        udf,
    output logic        c
);
    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [22:0] ma;
    logic [22:0] mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] prod;
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic        rnd;
    logic [23:0] mant_r;
    logic [9:0]  exp_f;

    assign sign   = a[31] ^ b[31];
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign ma     = a[22:0];
    assign mb     = b[22:0];
    assign a_nan  = (ea == 8'hFF) && (ma != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (mb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (ma == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (mb == 23'd0);
    // Denormal inputs are flushed to zero.
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign prod   = {24'd0, 1'b1, ma} * {24'd0, 1'b1, mb};
    assign c      = prod[47];

    always_comb begin
        p      = 32'd0;
        ovf    = 1'b0;
        udf    = 1'b0;
        mant   = prod[45:23];
        guard  = prod[22];
        sticky = |prod[21:0];
        if (c) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {23'd0, rnd};
        exp_f  = {2'b00, ea} + {2'b00, eb} - 10'd127 + {9'd0, c} + {9'd0, mant_r[23]};

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            p = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            p = {sign, 31'd0};
        end else if ($signed(exp_f) >= 10'sd255) begin
            p   = {sign, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else if ($signed(exp_f) <= 10'sd0) begin
            p   = {sign, 31'd0};
            udf = 1'b1;
        end else begin
            p = {sign, exp_f[7:0], mant_r[22:0]};
        end
    end
endmodule

// state | meaning
// IDLE  | waiting for a request
// MUL   | res <= res * base
// SQR   | base <= base * base, e <= e >> 1
// DONE  | result presented until out_ready
module fpow_int #(
    parameter int N_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        x,
    input  logic [N_WIDTH-1:0] n,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        y,
    output logic               ovf,
    output logic               udf
);
    localparam logic [31:0] FP_ONE = 32'h3F80_0000;

    typedef enum logic [1:0] {IDLE, MUL, SQR, DONE} state_t;

    state_t             state, state_nx;
    logic [31:0]        res, res_nx;
    logic [31:0]        base, base_nx;
    logic [N_WIDTH-1:0] e, e_nx;
    logic [31:0]        y_nx;
    logic               ovf_nx, udf_nx, out_valid_nx;

    logic [31:0]        mul_a;
    logic [31:0]        mul_p;
    logic               mul_ovf, mul_udf;
    logic               mul_c_unused;

    assign mul_a    = (state == MUL) ? res : base;
    assign in_ready = (state == IDLE) && !rst;

    fmul u_fmul (
        .a   (mul_a),
        .b   (base),
        .p   (mul_p),
        .ovf (mul_ovf),
        .udf (mul_udf),
        .c   (mul_c_unused)
    );

    always_comb begin
        state_nx     = state;
        res_nx       = res;
        base_nx      = base;
        e_nx         = e;
        y_nx         = y;
        ovf_nx       = ovf;
        udf_nx       = udf;
        out_valid_nx = out_valid;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    res_nx  = FP_ONE;
                    base_nx = x;
                    e_nx    = n;
                    ovf_nx  = 1'b0;
                    udf_nx  = 1'b0;
                    if (n == '0) begin
                        state_nx     = DONE;
                        y_nx         = FP_ONE;
                        out_valid_nx = 1'b1;
                    end else if (n[0]) begin
                        state_nx = MUL;
                    end else begin
                        state_nx = SQR;
                    end
`ifdef FPOW_EARLY_EXIT_EN
                    if (x[30:0] == FP_ONE[30:0]) begin
                        state_nx     = DONE;
                        y_nx         = n[0] ? x : FP_ONE;
                        res_nx       = y_nx;
                        out_valid_nx = 1'b1;
                    end else if (x[30:0] == 31'd0) begin
                        state_nx     = DONE;
                        y_nx         = (n == '0) ? FP_ONE : {x[31] & n[0], 31'd0};
                        res_nx       = y_nx;
                        out_valid_nx = 1'b1;
                    end
`endif
                end
            end
            MUL: begin
                res_nx = mul_p;
                ovf_nx = ovf | mul_ovf;
                udf_nx = udf | mul_udf;
                if ((e >> 1) == '0) begin
                    state_nx     = DONE;
                    y_nx         = mul_p;
                    out_valid_nx = 1'b1;
                end else begin
                    state_nx = SQR;
                end
            end
            SQR: begin
                base_nx  = mul_p;
                e_nx     = e >> 1;
                ovf_nx   = ovf | mul_ovf;
                udf_nx   = udf | mul_udf;
                // Shifted exponent is never zero here, so it always leads to a MUL eventually.
                state_nx = e_nx[0] ? MUL : SQR;
            end
            DONE: begin
                if (out_ready) begin
                    state_nx     = IDLE;
                    out_valid_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            res       <= 32'd0;
            base      <= 32'd0;
            e         <= '0;
            y         <= 32'd0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            res       <= res_nx;
            base      <= base_nx;
            e         <= e_nx;
            y         <= y_nx;
            ovf       <= ovf_nx;
            udf       <= udf_nx;
            out_valid <= out_valid_nx;
        end
    end
endmodule

// File: tb/tb_fpow_int.sv
// Scoreboard bench for fpow_int: directed vectors, expected results queued at issue,
// compared by an independent monitor when out_valid rises.

module tb_fpow_int;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [7:0]  n;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;
    logic        udf;

`ifdef FPOW_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        logic        udf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpow_int #(.N_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .udf       (udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: compares each new result the first cycle out_valid is seen.
    initial begin
        bit   seen;
        exp_t ex;
        seen = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || !out_valid) begin
                seen = 1'b0;
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sbq.size() == 0) begin
                        fail_now($sformatf("unexpected_output y=%h", y));
                    end else begin
                        ex = sbq.pop_front();
                        chk("y", y, ex.y);
                        chk("ovf", {31'd0, ovf}, {31'd0, ex.ovf});
                        chk("udf", {31'd0, udf}, {31'd0, ex.udf});
                        chk("latency", cyc - ex.acc, ex.lat);
                    end
                end
                if (out_ready) seen = 1'b0;
            end
        end
    end

    // Called between edges; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] xv, input logic [7:0] nv, input logic [31:0] ey,
                         input bit eo, input bit eu, input int ec, input bit push);
        int t;
        t = 0;
        x = xv;
        n = nv;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        if (push) sbq.push_back('{ey, eo, eu, ec, cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sbq.size() != 0) fail_now("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = 32'd0;
        n         = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_udf", {31'd0, udf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        issue(32'h4000_0000, 8'd10,  32'h4480_0000, 1'b0, 1'b0, 5, 1'b1);
        issue(32'h4040_0000, 8'd0,   32'h3F80_0000, 1'b0, 1'b0, 0, 1'b1);
        issue(32'hBFC0_0000, 8'd3,   32'hC058_0000, 1'b0, 1'b0, 3, 1'b1);
        issue(32'h7F00_0000, 8'd2,   32'h7F80_0000, 1'b1, 1'b0, 2, 1'b1);
        issue(32'h3F00_0000, 8'd5,   32'h3D00_0000, 1'b0, 1'b0, 4, 1'b1);
        issue(32'hC000_0000, 8'd7,   32'hC300_0000, 1'b0, 1'b0, 5, 1'b1);
        issue(32'h0080_0000, 8'd2,   32'h0000_0000, 1'b0, 1'b1, 2, 1'b1);
        issue(32'h3F80_0000, 8'd128, 32'h3F80_0000, 1'b0, 1'b0, EE ? 0 : 8, 1'b1);
        issue(32'hBF80_0000, 8'd255, 32'hBF80_0000, 1'b0, 1'b0, EE ? 0 : 15, 1'b1);
        issue(32'h8000_0000, 8'd3,   32'h8000_0000, 1'b0, 1'b0, EE ? 0 : 3, 1'b1);
        drain();

        // Backpressure: result must hold while new requests are pulsed and ignored.
        out_ready = 1'b0;
        issue(32'h4000_0000, 8'd1, 32'h4000_0000, 1'b0, 1'b0, 1, 1'b1);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!out_valid) fail_now("bp_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            x        = 32'h4100_0000 + i;
            n        = 8'd3;
            in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            chk("bp_y", y, 32'h4000_0000);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        issue(32'h4040_0000, 8'd2, 32'h4110_0000, 1'b0, 1'b0, 2, 1'b1);
        drain();

        // Reset mid-operation: the aborted request must never produce output.
        issue(32'h3FC0_0000, 8'd255, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        issue(32'h4000_0000, 8'd1, 32'h4000_0000, 1'b0, 1'b0, 1, 1'b1);
        drain();
        repeat (20) @(posedge clk);
        #1;
        chk("sb_empty", sbq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
